// File: rtl/reg_lock_arbiter.sv
// reg_lock_arbiter
// Two requesters compete for write sessions on one protected register. A
// session opens only after the winning requester's key matches UNLOCK_KEY.
// Repeated bad keys drive the block into a terminal lockdown that only
// resetn can clear.
//
// Optional feature: define REG_LOCK_TIMEOUT_EN to cap each OPEN session at
// TIMEOUT cycles. A timed-out owner may not be granted again until its
// request has dropped low at least once. Without the macro, a session stays
// open for as long as the owner holds its request, and TIMEOUT is only
// range-checked.

module reg_lock_arbiter #(
   parameter int         DATA_W     = 8,
   parameter logic [7:0] UNLOCK_KEY = 8'hA5,
   parameter int         MAX_FAIL   = 3,
   parameter int         TIMEOUT    = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [1:0]        req,
   input  logic [7:0]        key0,
   input  logic [7:0]        key1,
   input  logic [1:0]        wr_en,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic [DATA_W-1:0] wr_data1,
   output logic [1:0]        gnt,
   output logic              locked,
   output logic              deny,
   output logic              lockdown,
   output logic [DATA_W-1:0] data_q
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CHECK    = 2'd1,
      OPEN     = 2'd2,
      LOCKDOWN = 2'd3
   } state_t;

   localparam logic [2:0] MAX_FAIL_C = 3'(MAX_FAIL);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic [7:0]        key_q, key_d;
   logic [2:0]        fail_cnt_q, fail_cnt_d;
   logic              rr_q, rr_d;
   logic [DATA_W-1:0] data_d;

   logic [1:0]        eligible;
   logic              sel;
   logic              key_ok;
   logic [2:0]        fail_inc;
   logic              fail_limit;

`ifdef REG_LOCK_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   logic [7:0]        tmo_cnt_q, tmo_cnt_d;
   logic [1:0]        blocked_q, blocked_d;
`endif

   // Reject parameter values the counters cannot represent.
   if (MAX_FAIL < 1 || MAX_FAIL > 7) begin : g_bad_max_fail
      $error("reg_lock_arbiter: MAX_FAIL must be in 1..7");
   end
   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("reg_lock_arbiter: TIMEOUT must be in 2..255");
   end

   // Work out which requesters may win arbitration and how a key check ends.
   always_comb begin
`ifdef REG_LOCK_TIMEOUT_EN
      eligible = req & ~blocked_q;
`else
      eligible = req;
`endif
      if (eligible == 2'b11) begin
         sel = rr_q;
      end else begin
         sel = eligible[1];
      end
      key_ok     = (key_q == UNLOCK_KEY);
      fail_inc   = (fail_cnt_q == 3'd7) ? 3'd7 : fail_cnt_q + 3'd1;
      fail_limit = (fail_inc == MAX_FAIL_C);
   end

   // Session state machine: next state, register update and outputs.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      key_d      = key_q;
      fail_cnt_d = fail_cnt_q;
      rr_d       = rr_q;
      data_d     = data_q;
      gnt        = 2'b00;
      locked     = 1'b1;
      deny       = 1'b0;
      lockdown   = 1'b0;
`ifdef REG_LOCK_TIMEOUT_EN
      tmo_cnt_d  = tmo_cnt_q;
      blocked_d  = blocked_q & req;
`endif

      case (state_q)
         IDLE: begin
            if (|eligible) begin
               owner_d = sel;
               key_d   = sel ? key1 : key0;
               state_d = CHECK;
            end
         end

         CHECK: begin
            if (key_ok) begin
               state_d    = OPEN;
               fail_cnt_d = 3'd0;
`ifdef REG_LOCK_TIMEOUT_EN
               tmo_cnt_d  = 8'd0;
`endif
            end else begin
               deny       = 1'b1;
               fail_cnt_d = fail_inc;
               state_d    = fail_limit ? LOCKDOWN : IDLE;
            end
         end

         OPEN: begin
            gnt    = owner_q ? 2'b10 : 2'b01;
            locked = 1'b0;
`ifdef REG_LOCK_TIMEOUT_EN
            tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
            if (!req[owner_q]) begin
               state_d = IDLE;
               rr_d    = ~owner_q;
            end else begin
               if (wr_en[owner_q]) begin
                  data_d = owner_q ? wr_data1 : wr_data0;
               end
`ifdef REG_LOCK_TIMEOUT_EN
               if (tmo_cnt_q == TIMEOUT_LAST) begin
                  state_d            = IDLE;
                  rr_d               = ~owner_q;
                  blocked_d[owner_q] = 1'b1;
               end
`endif
            end
         end

         LOCKDOWN: begin
            lockdown = 1'b1;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Register the session state and the protected data; reset discards everything.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         key_q      <= 8'd0;
         fail_cnt_q <= 3'd0;
         rr_q       <= 1'b0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         key_q      <= key_d;
         fail_cnt_q <= fail_cnt_d;
         rr_q       <= rr_d;
         data_q     <= data_d;
      end
   end

`ifdef REG_LOCK_TIMEOUT_EN
   // Track cycles spent OPEN and which requesters are barred after a timeout.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tmo_cnt_q <= 8'd0;
         blocked_q <= 2'b00;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         blocked_q <= blocked_d;
      end
   end
`endif

endmodule

// File: doc/reg_lock_arbiter.md
REG_LOCK_ARBITER -- requirements
Module: reg_lock_arbiter

Interface
REQ-001 Param DATA_W, default 8, width of protected register and write data.
REQ-002 Param UNLOCK_KEY, default 8'hA5, key value that opens a write session.
REQ-003 Param MAX_FAIL, default 3, failed key attempts before permanent lockdown (range 1..7).
REQ-004 Param TIMEOUT, default 16, max OPEN cycles when timeout is compiled in (range 2..255).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 resetn  in  1  reset, asynchronous, active-low; the only way to leave lockdown.
REQ-007 req  in  2  per-requester session request, level, held for whole session.
REQ-008 key0, key1  in  8 each  requester key, sampled only in IDLE on grant selection.
REQ-009 wr_en  in  2  per-requester write strobe.
REQ-010 wr_data0, wr_data1  in  DATA_W each  per-requester write data.
REQ-011 gnt  out  2  one-hot session grant, at most one bit set.
REQ-012 locked  out  1  1 whenever no session is OPEN.
REQ-013 deny  out  1  one-cycle pulse on a failed key check.
REQ-014 lockdown  out  1  sticky, set after MAX_FAIL consecutive failures.
REQ-015 data_q  out  DATA_W  protected register value.

Function
REQ-016 FSM states SHALL be IDLE, CHECK, OPEN, LOCKDOWN.
REQ-017 IDLE: any req set -> latch owner and its key, go to CHECK next edge; both set -> owner is requester not granted last (rr pointer, reset value selects requester 0).
REQ-018 CHECK, one cycle: key match -> OPEN, fail_cnt cleared; mismatch -> deny=1 this cycle, fail_cnt+1, next IDLE, or LOCKDOWN if fail_cnt+1==MAX_FAIL.
REQ-019 fail_cnt SHALL be 3 bits, saturating, cleared only by successful check or reset.
REQ-020 OPEN: gnt[owner]=1, locked=0 combinationally from state.
REQ-021 OPEN: owner wr_en with owner req high -> data_q <= owner wr_data on next edge; zero added latency beyond that edge.
REQ-022 Non-owner wr_en, and any wr_en outside OPEN, SHALL leave data_q unchanged.
REQ-023 OPEN exit: owner req low -> IDLE next edge, rr pointer to other requester; a wr_en in the same cycle as req low SHALL be ignored.
REQ-024 Non-owner req during OPEN SHALL be held pending, no preemption.
REQ-025 LOCKDOWN: terminal; gnt=0, locked=1, lockdown=1, all req/wr_en ignored, data_q frozen.
REQ-026 Key change after CHECK entry SHALL have no effect on the check in progress.

Reset
REQ-027 resetn low, any state, asynchronously: state=IDLE, gnt=0, locked=1, deny=0, lockdown=0, fail_cnt=0, data_q=0, rr pointer=0.
REQ-028 Reset mid-OPEN SHALL discard the session; requester must re-present key after release.

Configuration
REQ-029 Macro REG_LOCK_TIMEOUT_EN defined: 8-bit counter from OPEN entry; at TIMEOUT cycles in OPEN force IDLE, timed-out owner ineligible until its req drops low once.
REQ-030 REG_LOCK_TIMEOUT_EN undefined: no counter, OPEN held indefinitely while owner req high; TIMEOUT unused.

Verification
REQ-031 Reset release, req=01, key0=A5, wr_en=01, wr_data0=3C -> gnt=01 two cycles after req, data_q=3C, locked=0; req=00 -> locked=1 next edge.
REQ-032 In OPEN owner 0, wr_en=10, wr_data1=FF -> data_q unchanged; req=11 from IDLE after owner 0 session -> owner 1 granted.
REQ-033 key0=00 three sessions -> deny pulse each, lockdown=1 after third; then key0=A5 -> gnt stays 00; resetn pulse -> lockdown=0, data_q=00.
REQ-034 Two failures, one success, two failures -> lockdown stays 0 (counter cleared by success).
REQ-035 resetn low mid-OPEN with data_q=3C -> data_q=00, gnt=00 immediately without clock edge.
REQ-036 REG_LOCK_TIMEOUT_EN defined, TIMEOUT=4, owner holds req -> gnt drops after 4 OPEN cycles, no regrant until req toggles low.
